// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encodings, default limits and width helpers for the alarm sequencer
package alarm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } state_t;

  localparam int DEF_TICK_DIV    = 50000;
  localparam int DEF_THRESH      = 100;
  localparam int DEF_TRIP_CNT    = 4;
  localparam int DEF_EXIT_T      = 10000;
  localparam int DEF_ENTRY_T     = 5000;
  localparam int DEF_ALARM_T     = 60000;
  localparam int DEF_BEEP_PERIOD = 1000;
  localparam int DEF_BEEP_ON     = 100;

  // A counter that only ever holds 0..limit-1 needs $clog2(limit) bits, but never fewer than one.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_prescaler
  import alarm_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CNT_W = cnt_w(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - arm/disarm sequencer driving the sound enable, with warning chirps and a sticky trip flag
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int THRESH      = DEF_THRESH,
  parameter int TRIP_CNT    = DEF_TRIP_CNT,
  parameter int EXIT_T      = DEF_EXIT_T,
  parameter int ENTRY_T     = DEF_ENTRY_T,
  parameter int ALARM_T     = DEF_ALARM_T,
  parameter int BEEP_PERIOD = DEF_BEEP_PERIOD,
  parameter int BEEP_ON     = DEF_BEEP_ON
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Arm,
  input  logic               Disarm,
  input  logic [7:0]         Distance,
  output logic               Sound_En,
  output logic [STATE_W-1:0] State,
  output logic               Tripped
);

  localparam int TMR_W  = cnt_w(max3(EXIT_T, ENTRY_T, ALARM_T));
  localparam int PH_W   = cnt_w(BEEP_PERIOD);
  localparam int NEAR_W = cnt_w(TRIP_CNT);

  localparam logic [TMR_W-1:0]  EXIT_LAST  = TMR_W'(EXIT_T - 1);
  localparam logic [TMR_W-1:0]  ENTRY_LAST = TMR_W'(ENTRY_T - 1);
  localparam logic [TMR_W-1:0]  ALARM_LAST = TMR_W'(ALARM_T - 1);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(BEEP_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_ON      = PH_W'(BEEP_ON);
  localparam logic [NEAR_W-1:0] NEAR_LAST  = NEAR_W'(TRIP_CNT - 1);
  // Nine bits so a threshold of 256 still means "every reading is near".
  localparam logic [8:0]        THRESH_V   = 9'(THRESH);

  logic               tick;
  logic               arm_prev, disarm_prev;
  logic               arm_edge, disarm_edge;
  logic               is_near;
  logic               changed;
  logic               timed_state;

  logic [STATE_W-1:0] state, state_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [PH_W-1:0]    phase, phase_d;
  logic [NEAR_W-1:0]  near_cnt, near_d;
  logic               tripped_d;
  logic               sound_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  assign arm_edge    = Arm & ~arm_prev;
  assign disarm_edge = Disarm & ~disarm_prev;
  assign is_near     = ({1'b0, Distance} < THRESH_V);
  assign State       = state;

  always_comb begin
    state_d   = state;
    tripped_d = Tripped;
    if (disarm_edge) begin
      state_d = DISARMED;
    end else begin
      case (state)
        DISARMED: begin
          if (arm_edge) begin
            state_d   = EXIT;
            tripped_d = 1'b0;
          end
        end
        EXIT: begin
          if (tick && timer == EXIT_LAST) state_d = ARMED;
        end
        ARMED: begin
          if (tick && is_near && near_cnt == NEAR_LAST) state_d = ENTRY;
        end
        ENTRY: begin
          if (tick && timer == ENTRY_LAST) begin
            state_d   = ALARM;
            tripped_d = 1'b1;
          end
        end
        ALARM: begin
          if (tick && timer == ALARM_LAST) state_d = ARMED;
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  assign changed     = (state_d != state);
  assign timed_state = (state == EXIT) || (state == ENTRY) || (state == ALARM);

  // Every state change restarts the delay, the chirp cadence and the near run.
  always_comb begin
    timer_d = timer;
    phase_d = phase;
    near_d  = near_cnt;
    if (changed) begin
      timer_d = '0;
      phase_d = '0;
      near_d  = '0;
    end else if (tick) begin
      if (timed_state) timer_d = timer + 1'b1;
      phase_d = (phase == PH_LAST) ? '0 : phase + 1'b1;
      if (state == ARMED) near_d = is_near ? near_cnt + 1'b1 : '0;
    end
  end

  // Decoded from next state/phase so the registered enable moves together with State.
  always_comb begin
    sound_d = 1'b0;
    if (state_d == ALARM) begin
      sound_d = 1'b1;
    end else if (state_d == EXIT || state_d == ENTRY) begin
      sound_d = (phase_d < PH_ON);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= DISARMED;
      timer       <= '0;
      phase       <= '0;
      near_cnt    <= '0;
      Tripped     <= 1'b0;
      Sound_En    <= 1'b0;
      arm_prev    <= 1'b1;
      disarm_prev <= 1'b1;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      phase       <= phase_d;
      near_cnt    <= near_d;
      Tripped     <= tripped_d;
      Sound_En    <= sound_d;
      arm_prev    <= Arm;
      disarm_prev <= Disarm;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed bench for alarm_controller with small timing parameters
module tb_alarm_controller;

  logic       CLK;
  logic       RST;
  logic       Arm;
  logic       Disarm;
  logic [7:0] Distance;
  logic       Sound_En;
  logic [2:0] State;
  logic       Tripped;

  int checks = 0;
  int errors = 0;
  int cyc;

  alarm_controller #(
    .TICK_DIV    (4),
    .THRESH      (100),
    .TRIP_CNT    (2),
    .EXIT_T      (3),
    .ENTRY_T     (2),
    .ALARM_T     (5),
    .BEEP_PERIOD (4),
    .BEEP_ON     (1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Arm      (Arm),
    .Disarm   (Disarm),
    .Distance (Distance),
    .Sound_En (Sound_En),
    .State    (State),
    .Tripped  (Tripped)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Mirrors the prescaler phase: a tick takes effect on posedges where cyc % 4 == 0.
  always @(posedge CLK) begin
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 4; i++) begin
      clk(1);
      if (cyc % 4 == 0) break;
    end
  endtask

  initial begin
    RST = 1'b0; Arm = 1'b1; Disarm = 1'b0; Distance = 8'd200;
    repeat (2) @(negedge CLK);
    check("rst_state", 8'(State), 8'd0);
    check("rst_sound", 8'(Sound_En), 8'd0);
    check("rst_tripped", 8'(Tripped), 8'd0);
    RST = 1'b1;
    clk(3);
    check("arm_held_no_act", 8'(State), 8'd0);

    Arm = 1'b0; clk(1);
    Arm = 1'b1; clk(1);
    check("exit_entered", 8'(State), 8'd1);
    check("exit_chirp_on", 8'(Sound_En), 8'd1);
    Arm = 1'b0;
    wait_tick();
    check("exit_t1_state", 8'(State), 8'd1);
    check("exit_t1_chirp_off", 8'(Sound_En), 8'd0);
    wait_tick();
    check("exit_t2_state", 8'(State), 8'd1);
    wait_tick();
    check("armed_after_exit", 8'(State), 8'd2);
    check("armed_quiet", 8'(Sound_En), 8'd0);

    Distance = 8'd50;
    wait_tick();
    check("near1_still_armed", 8'(State), 8'd2);
    wait_tick();
    check("entry_entered", 8'(State), 8'd3);
    check("entry_chirp_on", 8'(Sound_En), 8'd1);
    Distance = 8'd200;
    wait_tick();
    check("entry_t1_state", 8'(State), 8'd3);
    check("entry_t1_chirp_off", 8'(Sound_En), 8'd0);
    wait_tick();
    check("alarm_entered", 8'(State), 8'd4);
    check("alarm_siren", 8'(Sound_En), 8'd1);
    check("alarm_tripped", 8'(Tripped), 8'd1);
    repeat (4) wait_tick();
    check("alarm_t4_state", 8'(State), 8'd4);
    check("alarm_t4_siren", 8'(Sound_En), 8'd1);
    wait_tick();
    check("rearmed_state", 8'(State), 8'd2);
    check("rearmed_quiet", 8'(Sound_En), 8'd0);
    check("rearmed_tripped", 8'(Tripped), 8'd1);

    Distance = 8'd50;  wait_tick(); check("alt_50a", 8'(State), 8'd2);
    Distance = 8'd150; wait_tick(); check("alt_150", 8'(State), 8'd2);
    Distance = 8'd50;  wait_tick(); check("alt_50b", 8'(State), 8'd2);
    Distance = 8'd100; wait_tick(); check("alt_100a", 8'(State), 8'd2);
    Distance = 8'd50;  wait_tick(); check("alt_50c", 8'(State), 8'd2);
    Distance = 8'd100; wait_tick(); check("alt_100b", 8'(State), 8'd2);
    wait_tick();                    check("alt_100c", 8'(State), 8'd2);

    Distance = 8'd50;
    repeat (2) wait_tick();
    check("entry2_state", 8'(State), 8'd3);
    repeat (2) wait_tick();
    check("alarm2_state", 8'(State), 8'd4);
    Distance = 8'd200;
    clk(2);
    Arm = 1'b1; Disarm = 1'b1; clk(1);
    check("disarm_wins_state", 8'(State), 8'd0);
    check("disarm_wins_sound", 8'(Sound_En), 8'd0);
    check("disarm_keeps_tripped", 8'(Tripped), 8'd1);
    Arm = 1'b0; Disarm = 1'b0; clk(1);
    Arm = 1'b1; clk(1);
    check("rearm_state", 8'(State), 8'd1);
    check("rearm_clears_tripped", 8'(Tripped), 8'd0);
    Arm = 1'b0;

    repeat (3) wait_tick();
    check("armed3_state", 8'(State), 8'd2);
    Distance = 8'd50;
    repeat (2) wait_tick();
    check("entry3_state", 8'(State), 8'd3);
    check("entry3_sound", 8'(Sound_En), 8'd1);
    #2 RST = 1'b0;
    #1;
    check("async_rst_state", 8'(State), 8'd0);
    check("async_rst_sound", 8'(Sound_En), 8'd0);
    check("async_rst_tripped", 8'(Tripped), 8'd0);
    Distance = 8'd200;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    clk(2);
    Arm = 1'b1; clk(1);
    check("pre_force_state", 8'(State), 8'd1);
    check("pre_force_sound", 8'(Sound_En), 8'd1);
    Arm = 1'b0;
    force dut.state = 3'd6;
    clk(1);
    release dut.state;
    clk(1);
    check("illegal_recover_state", 8'(State), 8'd0);
    check("illegal_recover_sound", 8'(Sound_En), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing controller for the alarm sound path. It runs the arm/disarm state machine, qualifies the 8-bit distance reading, and produces the single enable that gates the tone generator and codec stream. It provides exit/entry warning chirps, a continuous siren with auto-silence, and a sticky tripped flag. It sits between the distance sensor front end and the sound generator.

## Interface
- TICK_DIV, 50000: clock cycles per tick (1 ms at 50 MHz); min 2
- THRESH, 100: distance strictly below this counts as "near"
- TRIP_CNT, 4: consecutive near ticks needed to trip; min 1
- EXIT_T, 10000: exit delay, ticks
- ENTRY_T, 5000: entry delay, ticks
- ALARM_T, 60000: siren duration before auto re-arm, ticks
- BEEP_PERIOD, 1000: chirp period, ticks
- BEEP_ON, 100: chirp on-time, ticks; BEEP_ON < BEEP_PERIOD
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- Arm  in  1  synchronous, debounced arm request; rising edge acts
- Disarm  in  1  synchronous, debounced disarm request; rising edge acts
- Distance  in  8  unsigned distance sample
- Sound_En  out  1  gates the sound generator (1 = audible)
- State  out  3  current state encoding
- Tripped  out  1  sticky "alarm occurred" flag

## Operation
- States: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 are illegal and recover to DISARMED on the next clock.
- Tick: free-running prescaler. Count 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0. It is not reset by state changes.
- Edge detect: previous-value registers for Arm and Disarm. An edge is cur=1 and prev=0.
- Transitions (Disarm edge beats every other event in the same cycle):
  - DISARMED: Arm edge -> EXIT; Tripped cleared.
  - EXIT: Disarm edge -> DISARMED; tick with timer==EXIT_T-1 -> ARMED.
  - ARMED: Disarm edge -> DISARMED; tick with Distance<THRESH and near==TRIP_CNT-1 -> ENTRY.
  - ENTRY: Disarm edge -> DISARMED; tick with timer==ENTRY_T-1 -> ALARM; Tripped set.
  - ALARM: Disarm edge -> DISARMED; tick with timer==ALARM_T-1 -> ARMED.
- An Arm edge outside DISARMED is ignored.
- Timer and beep phase: both clear to 0 on every state change and otherwise increment on tick. Phase wraps at BEEP_PERIOD. Timer never exceeds its state's limit.
- Near counter:
  - Active only in ARMED.
  - On tick: Distance<THRESH increments it; Distance>=THRESH clears it.
  - Cleared on every state change.
  - Distance is sampled only on tick cycles.
- Sound_En is decoded from registered state and phase, so it is glitch-free:
  - 1 in ALARM.
  - In EXIT/ENTRY, equals (phase < BEEP_ON).
  - 0 otherwise.
- Tripped survives disarm and clears only on the next arm.
- Counter widths: $clog2 of each limit. Comparisons are unsigned. No wrap is possible because each counter clears at its limit.

## Timing
- Reset values:
  - State=DISARMED, Sound_En=0, Tripped=0.
  - Prescaler, timer, phase and near count = 0.
  - Arm/Disarm prev registers = 1, so an input held high through reset does not act.
- Edge latency: an edge sampled at clock k updates State after clock k; it is visible from cycle k+1.
- Delay timing: EXIT lasts exactly EXIT_T ticks from entry (ENTRY and ALARM likewise), ±1 tick of prescaler phase.
- Sound_En timing: changes in the same cycle as State and phase.
- Reset mid-operation: immediate asynchronous return to reset values, including during ALARM.

## Structure
- Shared package/include alarm_pkg: state encodings (DISARMED..ALARM), state width constant, default parameter values.
- Sub-module tick_prescaler (parameter TICK_DIV; ports CLK, RST, tick). The FSM, counters and output decode stay in alarm_controller.

## Test plan
Parameters for all scenarios: TICK_DIV=4, THRESH=100, TRIP_CNT=2, EXIT_T=3, ENTRY_T=2, ALARM_T=5, BEEP_PERIOD=4, BEEP_ON=1.
- Reset with Arm held high, then released and re-pulsed -> State stays 0 while held through reset; the re-pulse gives State=1 one cycle after the edge, and State=2 after 3 ticks. Sound_En=1 exactly during tick 0 of the exit phase.
- Armed, Distance=50 for 2 ticks -> State=3; then 2 ticks -> State=4, Sound_En=1, Tripped=1. After 5 ticks -> State=2, Sound_En=0, Tripped still 1.
- Armed, Distance alternating 50/150 per tick -> near count never reaches 2, State stays 2. Distance=100 does not count as near.
- In ALARM, Arm and Disarm edges in the same cycle -> State=0 next cycle, Sound_En=0, Tripped stays 1. A following Arm edge clears Tripped and gives State=1.
- RST asserted mid-ENTRY -> State=0 and Sound_En=0 asynchronously, before the next clock edge.
- Force State register to 6 -> State=0 after the next clock, Sound_En=0.
